// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data memory and the pipeline decoder.
//   - MemRead load codes (LNO, LW, LH, LHU, LB, LBU)
//   - MemWrite store codes (SNO, SH, SB, SW)
//   - state_e: clear-sequencer states (INIT, RUN)
//   - lane_shift(): bit position of a byte lane within a 32-bit word
package dm_pkg;

  localparam logic [2:0] LNO = 3'b000;
  localparam logic [2:0] LW  = 3'b001;
  localparam logic [2:0] LH  = 3'b010;
  localparam logic [2:0] LHU = 3'b011;
  localparam logic [2:0] LB  = 3'b100;
  localparam logic [2:0] LBU = 3'b101;

  localparam logic [1:0] SNO = 2'b00;
  localparam logic [1:0] SH  = 2'b01;
  localparam logic [1:0] SB  = 2'b10;
  localparam logic [1:0] SW  = 2'b11;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  // Little-endian: offset k sits at bit 8k. Big-endian: at bit 24-8k = 8*(k^3).
  function automatic logic [4:0] lane_shift(input logic [1:0] offset, input logic big_endian);
    return {offset ^ {2{big_endian}}, 3'b000};
  endfunction

endpackage

// File: rtl/dm_sync_if.sv
// dm_sync_if: MEM-stage access bus between the pipeline and the data memory.
//   req/MemRead/MemWrite/DataAddr/WriteData : pipeline -> memory
//   ready/ReadData/rvalid/misalign           : memory -> pipeline
// master = pipeline side, slave = memory side.
interface dm_sync_if;
  import dm_pkg::*;

  logic        req;
  logic [2:0]  MemRead;
  logic [1:0]  MemWrite;
  logic [31:0] DataAddr;
  logic [31:0] WriteData;
  logic        ready;
  logic [31:0] ReadData;
  logic        rvalid;
  logic        misalign;

  modport master (
    output req, MemRead, MemWrite, DataAddr, WriteData,
    input  ready, ReadData, rvalid, misalign
  );

  modport slave (
    input  req, MemRead, MemWrite, DataAddr, WriteData,
    output ready, ReadData, rvalid, misalign
  );

endinterface

// File: rtl/dm_lane.sv
// dm_lane: combinational byte-lane steering for the data memory.
//   offset_i  : DataAddr[1:0]
//   st_type_i : MemWrite code; wdata_i right-justified store data
//   be_o      : byte enables (be_o[i] covers word bits [8i +: 8])
//   wlane_o   : store data moved onto its lanes
//   ld_type_i : MemRead code; rword_i the addressed memory word
//   rdata_o   : extracted and extended load value
module dm_lane import dm_pkg::*; #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  offset_i,
  input  logic [1:0]  st_type_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  ld_type_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o
);

  logic [4:0]         b_sh;
  logic [4:0]         h_sh;
  logic [31:0]        mask;
  logic signed [7:0]  rbyte;
  logic signed [15:0] rhalf;

  always_comb begin
    b_sh = lane_shift(offset_i, BIG_ENDIAN);
    // A halfword occupies the lower-positioned of its two byte lanes: the
    // even offset for little-endian, the odd one for big-endian.
    h_sh = lane_shift({offset_i[1], BIG_ENDIAN}, BIG_ENDIAN);

    mask    = '0;
    wlane_o = '0;
    case (st_type_i)
      SB: begin
        mask    = 32'h0000_00FF << b_sh;
        wlane_o = {24'h0, wdata_i[7:0]} << b_sh;
      end
      SH: begin
        mask    = 32'h0000_FFFF << h_sh;
        wlane_o = {16'h0, wdata_i[15:0]} << h_sh;
      end
      SW: begin
        mask    = '1;
        wlane_o = wdata_i;
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) be_o[i] = mask[8*i];

    rbyte = 8'(rword_i >> b_sh);
    rhalf = 16'(rword_i >> h_sh);
    case (ld_type_i)
      LW:      rdata_o = rword_i;
      LH:      rdata_o = 32'(rhalf);
      LHU:     rdata_o = {16'h0, rhalf};
      LB:      rdata_o = 32'(rbyte);
      LBU:     rdata_o = {24'h0, rbyte};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dm_sync.sv
// dm_sync: byte-lane data memory for the MEM stage, 2**ADDR_W 32-bit words.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dm_sync_if.slave (req, MemRead, MemWrite, DataAddr, WriteData
//              in; ready, ReadData, rvalid, misalign out)
// After reset a clear sequencer zeroes one word per cycle (INIT), then the
// block accepts one access per cycle (RUN). Loads return one cycle later.
module dm_sync import dm_pkg::*; #(
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic      clk,
  input logic      rst,
  dm_sync_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic              misalign_q;

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic              is_store, is_load, aligned;
  logic              accept, st_en, ld_en, mis;
  logic [3:0]        be;
  logic [31:0]       wlane, rword, lane_rdata;
  logic              unused_addr_hi;

  // Upper address bits alias onto the array.
  assign idx            = bus.DataAddr[ADDR_W+1:2];
  assign off            = bus.DataAddr[1:0];
  assign unused_addr_hi = ^bus.DataAddr[31:ADDR_W+2];
  assign rword          = mem_q[idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_W{1'b1}}) state_d = RUN;
    end
  end

  // A store wins over a simultaneous load; alignment follows the executing op.
  always_comb begin
    is_store = (bus.MemWrite != SNO);
    is_load  = 1'b0;
    aligned  = 1'b1;
    case (bus.MemRead)
      LNO:                  is_load = 1'b0;
      LW, LH, LHU, LB, LBU: is_load = !is_store;
      default:              is_load = 1'b0;
    endcase
    if (is_store) begin
      case (bus.MemWrite)
        SW:      aligned = (off == 2'b00);
        SH:      aligned = !off[0];
        default: aligned = 1'b1;
      endcase
    end else begin
      case (bus.MemRead)
        LW:      aligned = (off == 2'b00);
        LH, LHU: aligned = !off[0];
        default: aligned = 1'b1;
      endcase
    end
  end

  assign accept = (state_q == RUN) && bus.req && !rst;
  assign st_en  = accept && is_store && aligned;
  assign ld_en  = accept && is_load;
  assign mis    = accept && (is_store || is_load) && !aligned;

  dm_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .offset_i  (off),
    .st_type_i (bus.MemWrite),
    .wdata_i   (bus.WriteData),
    .ld_type_i (bus.MemRead),
    .rword_i   (rword),
    .be_o      (be),
    .wlane_o   (wlane),
    .rdata_o   (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory array: clear writes during INIT, lane-masked stores during RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem_q[cnt_q] <= '0;
      end else if (st_en) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  // Load result register: one-cycle latency, holds until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rvalid_q   <= ld_en;
      misalign_q <= mis;
      if (ld_en) rdata_q <= aligned ? lane_rdata : '0;
    end
  end

  assign bus.ready    = (state_q == RUN);
  assign bus.ReadData = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_dm_sync.sv
// tb_dm_sync: drives a big-endian and a little-endian dm_sync with identical
// stimulus and compares both against a byte-addressed reference memory.
module tb_dm_sync;
  import dm_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int NBYTES = 4*DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_sync_if bus_be ();
  dm_sync_if bus_le ();

  dm_sync #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .rst(rst), .bus(bus_be));
  dm_sync #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .rst(rst), .bus(bus_le));

  int checks = 0;
  int errors = 0;

  // Reference: plain byte memory per endianness ([1] = big, [0] = little).
  logic [7:0]  mb [2][NBYTES];
  logic [31:0] exp_rd [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [2:0] rd, input logic [1:0] wr,
                       input logic [31:0] a, input logic [31:0] wd);
    bus_be.req = req; bus_be.MemRead = rd; bus_be.MemWrite = wr;
    bus_be.DataAddr = a; bus_be.WriteData = wd;
    bus_le.req = req; bus_le.MemRead = rd; bus_le.MemWrite = wr;
    bus_le.DataAddr = a; bus_le.WriteData = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int e = 0; e < 2; e++) begin
      exp_rd[e] = '0;
      for (int b = 0; b < NBYTES; b++) mb[e][b] = 8'h00;
    end
  endtask

  // Byte-level meaning of one access; updates the model and returns the
  // expected rvalid/misalign pulses.
  function automatic void model(input int e, input logic req, input logic [2:0] rd,
                                input logic [1:0] wr, input logic [31:0] a,
                                input logic [31:0] wd, output logic rv, output logic mis);
    int          base, size, k;
    logic        st, ld, sgn, al;
    logic [31:0] v;
    base = int'(a[11:0]);
    st   = req && (wr != SNO);
    ld   = req && !st && (rd inside {LW, LH, LHU, LB, LBU});
    size = 4;
    sgn  = 1'b0;
    if (st) size = (wr == SB) ? 1 : (wr == SH) ? 2 : 4;
    else if (ld) begin
      case (rd)
        LH:      begin size = 2; sgn = 1'b1; end
        LHU:     size = 2;
        LB:      begin size = 1; sgn = 1'b1; end
        LBU:     size = 1;
        default: size = 4;
      endcase
    end
    al  = (base % size) == 0;
    mis = (st || ld) && !al;
    rv  = ld;
    if (st && al) begin
      for (int i = 0; i < size; i++) begin
        k = (e == 1) ? size - 1 - i : i;
        mb[e][base + i] = wd[8*k +: 8];
      end
    end
    if (ld) begin
      if (!al) exp_rd[e] = '0;
      else begin
        v = '0;
        for (int i = 0; i < size; i++) begin
          if (e == 1) v = {v[23:0], mb[e][base + i]};
          else        v[8*i +: 8] = mb[e][base + i];
        end
        if (sgn && v[8*size-1]) for (int j = 8*size; j < 32; j++) v[j] = 1'b1;
        exp_rd[e] = v;
      end
    end
  endfunction

  task automatic do_access(input string tag, input logic req, input logic [2:0] rd,
                           input logic [1:0] wr, input logic [31:0] a, input logic [31:0] wd);
    logic rv, mis;
    drive(req, rd, wr, a, wd);
    step();
    model(1, req, rd, wr, a, wd, rv, mis);
    check({tag, ".be.rvalid"},   32'(bus_be.rvalid),   32'(rv));
    check({tag, ".be.misalign"}, 32'(bus_be.misalign), 32'(mis));
    check({tag, ".be.rdata"},    bus_be.ReadData,      exp_rd[1]);
    model(0, req, rd, wr, a, wd, rv, mis);
    check({tag, ".le.rvalid"},   32'(bus_le.rvalid),   32'(rv));
    check({tag, ".le.misalign"}, 32'(bus_le.misalign), 32'(mis));
    check({tag, ".le.rdata"},    bus_le.ReadData,      exp_rd[0]);
    drive(1'b0, LNO, SNO, 32'h0, 32'h0);
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (bus_be.ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    check({tag, ".cycles"},   32'(n),            32'(DEPTH));
    check({tag, ".le.ready"}, 32'(bus_le.ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b1;
    drive(1'b0, LNO, SNO, 32'h0, 32'h0);
    clear_model();
    repeat (3) step();

    check("rst.be.ready",    32'(bus_be.ready),    32'd0);
    check("rst.be.rvalid",   32'(bus_be.rvalid),   32'd0);
    check("rst.be.misalign", 32'(bus_be.misalign), 32'd0);
    check("rst.be.rdata",    bus_be.ReadData,      32'd0);
    check("rst.le.ready",    32'(bus_le.ready),    32'd0);
    check("rst.le.rvalid",   32'(bus_le.rvalid),   32'd0);
    check("rst.le.misalign", 32'(bus_le.misalign), 32'd0);
    check("rst.le.rdata",    bus_le.ReadData,      32'd0);

    rst = 1'b0;
    wait_clear("clear1");
    for (int i = 0; i < DEPTH; i++) do_access($sformatf("sweep%0d", i), 1'b1, LW, SNO, 32'(4*i), 32'h0);

    // Lane selection sequence at 0x10
    do_access("sw10",   1'b1, LNO, SW, 32'h10, 32'h1122_3344);
    do_access("sb11",   1'b1, LNO, SB, 32'h11, 32'h0000_00AA);
    do_access("lw10",   1'b1, LW,  SNO, 32'h10, 32'h0);
    check("plan.be.lw10", bus_be.ReadData, 32'h11AA_3344);
    check("plan.le.lw10", bus_le.ReadData, 32'h1122_AA44);
    do_access("lb11",   1'b1, LB,  SNO, 32'h11, 32'h0);
    check("plan.be.lb11", bus_be.ReadData, 32'hFFFF_FFAA);
    do_access("lbu11",  1'b1, LBU, SNO, 32'h11, 32'h0);
    check("plan.be.lbu11", bus_be.ReadData, 32'h0000_00AA);
    do_access("sh12",   1'b1, LNO, SH, 32'h12, 32'h0000_BEEF);
    do_access("lhu12",  1'b1, LHU, SNO, 32'h12, 32'h0);
    check("plan.be.lhu12", bus_be.ReadData, 32'h0000_BEEF);
    check("plan.le.lhu12", bus_le.ReadData, 32'h0000_BEEF);
    do_access("sh10",   1'b1, LNO, SH, 32'h10, 32'h0000_8001);
    do_access("lh10",   1'b1, LH,  SNO, 32'h10, 32'h0);
    check("plan.le.lh10", bus_le.ReadData, 32'hFFFF_8001);

    // Misaligned accesses
    do_access("sw20",   1'b1, LNO, SW, 32'h20, 32'h1234_5678);
    do_access("sw22mis", 1'b1, LNO, SW, 32'h22, 32'hCAFE_F00D);
    check("plan.be.mis", 32'(bus_be.misalign), 32'd1);
    do_access("lw20",   1'b1, LW,  SNO, 32'h20, 32'h0);
    check("plan.be.lw20", bus_be.ReadData, 32'h1234_5678);
    do_access("lh13mis", 1'b1, LH, SNO, 32'h13, 32'h0);
    check("plan.le.lh13.rd", bus_le.ReadData, 32'h0);
    check("plan.le.lh13.rv", 32'(bus_le.rvalid), 32'd1);

    // Back-to-back and simultaneous store+load
    do_access("sw40",   1'b1, LNO, SW, 32'h40, 32'hDEAD_BEEF);
    do_access("lw40",   1'b1, LW,  SNO, 32'h40, 32'h0);
    check("plan.be.lw40", bus_be.ReadData, 32'hDEAD_BEEF);
    do_access("swlw44", 1'b1, LW,  SW, 32'h44, 32'h55AA_55AA);
    check("plan.be.swlw.rv", 32'(bus_be.rvalid), 32'd0);
    do_access("lw44",   1'b1, LW,  SNO, 32'h44, 32'h0);
    do_access("rd110",  1'b1, 3'b110, SNO, 32'h44, 32'h0);
    do_access("rd111",  1'b1, 3'b111, SNO, 32'h44, 32'h0);

    // Randomized traffic over a small aliased window
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
      do_access($sformatf("rnd%0d", i), 1'b1 && ($urandom_range(0, 7) != 0),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : SNO,
                ra, $urandom());
    end

    // Reset while a load is in flight
    do_access("lw44b", 1'b1, LW, SNO, 32'h44, 32'h0);
    drive(1'b1, LW, SNO, 32'h40, 32'h0);
    rst = 1'b1;
    step();
    check("midrst.be.rvalid",   32'(bus_be.rvalid),   32'd0);
    check("midrst.be.ready",    32'(bus_be.ready),    32'd0);
    check("midrst.be.misalign", 32'(bus_be.misalign), 32'd0);
    check("midrst.le.rvalid",   32'(bus_le.rvalid),   32'd0);
    check("midrst.le.ready",    32'(bus_le.ready),    32'd0);
    rst = 1'b0;
    drive(1'b0, LNO, SNO, 32'h0, 32'h0);
    clear_model();
    wait_clear("clear2");
    do_access("post.lw40", 1'b1, LW, SNO, 32'h40, 32'h0);
    check("plan.be.post40", bus_be.ReadData, 32'h0);
    check("plan.le.post40", bus_le.ReadData, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
